instruction_fetch_unit: RTL

//  IF stage of the RV32IM pipeline: owns the PC, drives the instruction-memory read interface and loads
//  the IF/ID register that feeds the control unit and register file. Handles stalls from the hazard

---
 rtl/instruction_fetch_unit_pkg.sv | 27 ++
 rtl/instruction_fetch_unit_if.sv | 27 ++
 rtl/instruction_fetch_unit_jal_predecoder.sv | 16 +
 rtl/instruction_fetch_unit.sv | 117 +++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: opcode constants, the
// bubble encoding, fetch FSM state codes and the IF/ID register layout.
package instruction_fetch_unit_pkg;

  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0]  OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [31:0] NOP_ENC       = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  // J-type immediate, sign-extended to 32 bits.
  function automatic logic [31:0] jal_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, hazard/redirect
// controls from the pipeline, and the IF/ID register outputs.
//   master : the fetch unit (drives imem_addr/imem_read and IF/ID)
//   slave  : memory + pipeline side
interface instruction_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_read;
  logic        imem_busy;
  logic [31:0] imem_instr;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        if_id_predicted;

  modport master (
    output imem_addr, imem_read, if_id_pc, if_id_instruction, if_id_valid, if_id_predicted,
    input  imem_busy, imem_instr, stall, branch_taken, branch_target
  );

  modport slave (
    input  imem_addr, imem_read, if_id_pc, if_id_instruction, if_id_valid, if_id_predicted,
    output imem_busy, imem_instr, stall, branch_taken, branch_target
  );
endinterface

// File: rtl/instruction_fetch_unit_jal_predecoder.sv
// Combinational JAL predecoder: flags a JAL and computes its target.
//   instr_i  : fetched instruction
//   pc_i     : address it was fetched from
//   is_jal_o : opcode is JAL
//   target_o : pc_i + J-immediate
module jal_predecoder
  import instruction_fetch_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  output logic        is_jal_o,
  output logic [31:0] target_o
);
  assign is_jal_o = (instr_i[6:0] == OPCODE_JAL);
  assign target_o = pc_i + jal_imm(instr_i);
endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues instruction-memory reads and loads the IF/ID
// register. Handles hazard stalls, EX redirects and multi-cycle memory.
// Optional feature macro: JAL_PREDECODE_EN (redirect JALs in IF and mark them
// predicted; otherwise if_id_predicted is tied 0).
// Ports:
//   clk_i  : clock, all state on rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : instruction_fetch_unit_if.master (imem port, stall/redirect, IF/ID)
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_e state_q;
  logic [31:0]  pc_q;
  logic [31:0]  tgt_q;
  logic         read_q;
  if_id_t       ifid_q;
  logic [31:0]  seq_pc;
  logic [31:0]  redir_pc;

  assign redir_pc = {bus.branch_target[31:2], 2'b00};

`ifdef JAL_PREDECODE_EN
  logic        is_jal;
  logic [31:0] jal_tgt;
  logic        pred_q;

  jal_predecoder u_jal_predecoder (
    .instr_i  (bus.imem_instr),
    .pc_i     (pc_q),
    .is_jal_o (is_jal),
    .target_o (jal_tgt)
  );

  assign seq_pc              = is_jal ? jal_tgt : pc_q + 32'd4;
  assign bus.if_id_predicted = pred_q;

  // Prediction flag tracks the IF/ID register: set only when an accepted
  // response is a JAL, cleared whenever a bubble or other instruction loads.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pred_q <= 1'b0;
    end else if (bus.branch_taken) begin
      pred_q <= 1'b0;
    end else if (state_q == ST_FETCH && !bus.stall) begin
      pred_q <= !bus.imem_busy && is_jal;
    end else if (state_q == ST_DRAIN) begin
      pred_q <= 1'b0;
    end
  end
`else
  assign seq_pc              = pc_q + 32'd4;
  assign bus.if_id_predicted = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      read_q  <= 1'b0;
      ifid_q  <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (bus.branch_taken) begin
      ifid_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      read_q <= 1'b1;
      // An outstanding access must complete before the address may change,
      // so park the target and drain. A redirect inside DRAIN only retargets.
      if ((state_q == ST_FETCH || state_q == ST_DRAIN) && bus.imem_busy) begin
        tgt_q   <= redir_pc;
        state_q <= ST_DRAIN;
      end else begin
        pc_q    <= redir_pc;
        state_q <= ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_BOOT: begin
          state_q <= ST_FETCH;
          read_q  <= 1'b1;
        end
        ST_FETCH: begin
          if (!bus.stall) begin
            if (bus.imem_busy) begin
              ifid_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
            end else begin
              ifid_q <= '{pc: pc_q, instr: bus.imem_instr, valid: 1'b1};
              pc_q   <= seq_pc;
            end
          end
        end
        ST_DRAIN: begin
          // Data returned here belongs to the pre-redirect path: dropped.
          ifid_q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
          if (!bus.imem_busy) begin
            pc_q    <= tgt_q;
            state_q <= ST_FETCH;
          end
        end
        default: state_q <= ST_BOOT;
      endcase
    end
  end

  assign bus.imem_addr         = pc_q;
  assign bus.imem_read         = read_q;
  assign bus.if_id_pc          = ifid_q.pc;
  assign bus.if_id_instruction = ifid_q.instr;
  assign bus.if_id_valid       = ifid_q.valid;

endmodule
